// File: rtl/masked_sbox_sched.sv
// rtl/masked_sbox_sched.sv - scheduler for the 3-share masked PRINCE S-box pipeline
module masked_sbox_sched #(
  parameter int NUM_NIBBLES = 16,
  parameter int NUM_STAGES  = 3,
  parameter int IDXW        = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  input  logic                  rnd_valid,
  output logic                  rnd_ack,
  output logic [IDXW-1:0]       rd_idx,
  output logic [NUM_STAGES-1:0] stage_en,
  output logic                  wr_en,
  output logic [IDXW-1:0]       wr_idx
);

  // One extra bit so the issue counter can reach NUM_NIBBLES without wrapping.
  localparam int CW = IDXW + 1;
  // Selects every stage except the last; empty (all zero) for a single-stage pipeline.
  localparam logic [NUM_STAGES-1:0] FRONT_MASK =
    NUM_STAGES'((64'd1 << (NUM_STAGES - 1)) - 64'd1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         issue_cnt;
  logic [NUM_STAGES-1:0] vld;
  logic [IDXW-1:0]       idx [NUM_STAGES];
  logic                  adv;
  logic                  pend;

  assign pend   = (issue_cnt < CW'(NUM_NIBBLES));
  assign rd_idx = issue_cnt[IDXW-1:0];
  assign wr_idx = idx[NUM_STAGES-1];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state plus stage/handshake strobes; the whole pipeline stalls without fresh randomness.
  always_comb begin
    state_d  = state_q;
    adv      = 1'b0;
    stage_en = '0;
    wr_en    = 1'b0;
    busy     = (state_q == RUN);
    done     = (state_q == DONE);
    case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN: begin
        adv         = rnd_valid;
        stage_en[0] = adv & pend;
        for (int i = 1; i < NUM_STAGES; i++) stage_en[i] = adv & vld[i-1];
        wr_en = adv & vld[NUM_STAGES-1];
        // Last write-back: nothing left to issue and nothing in flight upstream.
        if (wr_en && !pend && ((vld & FRONT_MASK) == '0)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    rnd_ack = |stage_en;
  end

  // Issue counter and per-stage valid/index shift chain; moves only on an advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      issue_cnt <= '0;
      vld       <= '0;
      for (int i = 0; i < NUM_STAGES; i++) idx[i] <= '0;
    end else if (state_q == IDLE && start) begin
      issue_cnt <= '0;
    end else if (adv) begin
      vld[0] <= pend;
      idx[0] <= issue_cnt[IDXW-1:0];
      for (int i = 1; i < NUM_STAGES; i++) begin
        vld[i] <= vld[i-1];
        idx[i] <= idx[i-1];
      end
      if (pend) issue_cnt <= issue_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_masked_sbox_sched.sv
// tb/tb_masked_sbox_sched.sv - self-checking bench for masked_sbox_sched
module tb_masked_sbox_sched;

  localparam int N = 16;
  localparam int S = 3;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         rnd_valid = 1'b0;
  logic         busy, done, rnd_ack, wr_en;
  logic [W-1:0] rd_idx, wr_idx;
  logic [S-1:0] stage_en;

  logic         start1 = 1'b0;
  logic         rnd_valid1 = 1'b1;
  logic         busy1, done1, rnd_ack1, wr_en1;
  logic [0:0]   rd_idx1, wr_idx1, stage_en1;

  int checks = 0;
  int errors = 0;

  // Abstract model: phase (0 idle, 1 run, 2 done) and number of advances taken in this pass.
  int m_phase = 0;
  int m_a = 0;
  int cyc = 0;
  int done_cyc = -1;
  int last_wr_cyc = -1;
  bit expect_zero_idx = 0;
  int wr_q[$];

  always #5 clk = ~clk;

  masked_sbox_sched #(.NUM_NIBBLES(N), .NUM_STAGES(S), .IDXW(W)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .rnd_valid(rnd_valid), .rnd_ack(rnd_ack), .rd_idx(rd_idx),
    .stage_en(stage_en), .wr_en(wr_en), .wr_idx(wr_idx)
  );

  masked_sbox_sched #(.NUM_NIBBLES(1), .NUM_STAGES(1), .IDXW(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
    .rnd_valid(rnd_valid1), .rnd_ack(rnd_ack1), .rd_idx(rd_idx1),
    .stage_en(stage_en1), .wr_en(wr_en1), .wr_idx(wr_idx1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: apply inputs, compare against the model mid-cycle, then advance the model.
  task automatic tick(input logic r, input logic st, input logic rv);
    logic [S-1:0] e_en;
    logic         e_wr;
    rst = r; start = st; rnd_valid = rv;
    @(negedge clk);
    e_en = '0;
    e_wr = 1'b0;
    if (m_phase == 1 && rv) begin
      for (int s = 0; s < S; s++)
        if (m_a - s >= 0 && m_a - s < N) e_en[s] = 1'b1;
      if (m_a - S >= 0 && m_a - S < N) e_wr = 1'b1;
    end
    chk("busy", 32'(busy), 32'(m_phase == 1));
    chk("done", 32'(done), 32'(m_phase == 2));
    chk("stage_en", 32'(stage_en), 32'(e_en));
    chk("rnd_ack", 32'(rnd_ack), 32'(|e_en));
    chk("ack_vs_en", 32'(rnd_ack), 32'(|stage_en));
    chk("wr_en", 32'(wr_en), 32'(e_wr));
    if (e_en[0]) chk("rd_idx", 32'(rd_idx), 32'(m_a));
    if (e_wr)    chk("wr_idx", 32'(wr_idx), 32'(m_a - S));
    if (expect_zero_idx) begin
      chk("rst_rd_idx", 32'(rd_idx), 32'd0);
      chk("rst_wr_idx", 32'(wr_idx), 32'd0);
      expect_zero_idx = 0;
    end
    if (wr_en) begin
      wr_q.push_back(int'(wr_idx));
      last_wr_cyc = cyc;
    end
    if (done) done_cyc = cyc;
    @(posedge clk);
    if (r) begin
      m_phase = 0;
      m_a = 0;
    end else begin
      case (m_phase)
        0: if (st) begin m_phase = 1; m_a = 0; end
        1: if (rv) begin
             if (m_a == N + S - 1) m_phase = 2;
             m_a++;
           end
        default: m_phase = 0;
      endcase
    end
    cyc++;
    #1;
  endtask

  task automatic new_test();
    cyc = 0;
    done_cyc = -1;
    last_wr_cyc = -1;
    wr_q.delete();
  endtask

  task automatic chk_order(input string tag);
    chk({tag, "_count"}, 32'(wr_q.size()), 32'(N));
    for (int i = 0; i < wr_q.size() && i < N; i++)
      chk({tag, "_order"}, 32'(wr_q[i]), 32'(i));
  endtask

  initial begin
    @(posedge clk);
    #1;
    // Reset state.
    expect_zero_idx = 1;
    tick(1, 0, 1);
    tick(0, 0, 1);

    // Single-nibble, single-stage configuration.
    start1 = 1'b1;
    @(negedge clk);
    chk("t5_c0_busy", 32'(busy1), 32'd0);
    @(posedge clk); #1; start1 = 1'b0;
    @(negedge clk);
    chk("t5_c1_en", 32'(stage_en1), 32'd1);
    chk("t5_c1_rd", 32'(rd_idx1), 32'd0);
    chk("t5_c1_wr", 32'(wr_en1), 32'd0);
    chk("t5_c1_ack", 32'(rnd_ack1), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t5_c2_wr", 32'(wr_en1), 32'd1);
    chk("t5_c2_wridx", 32'(wr_idx1), 32'd0);
    chk("t5_c2_en", 32'(stage_en1), 32'd0);
    chk("t5_c2_done", 32'(done1), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t5_c3_done", 32'(done1), 32'd1);
    chk("t5_c3_busy", 32'(busy1), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t5_c4_done", 32'(done1), 32'd0);
    @(posedge clk); #1;

    // Test 1: free-running randomness.
    new_test();
    for (int c = 0; c < 23; c++) tick(0, c == 0, 1);
    chk("t1_done_cyc", 32'(done_cyc), 32'd20);
    chk("t1_last_wr", 32'(last_wr_cyc), 32'd19);
    chk_order("t1");

    // Test 2: randomness withheld in cycles 5..7.
    new_test();
    for (int c = 0; c < 26; c++) tick(0, c == 0, !(c >= 5 && c <= 7));
    chk("t2_done_cyc", 32'(done_cyc), 32'd23);
    chk("t2_last_wr", 32'(last_wr_cyc), 32'd22);
    chk_order("t2");

    // Test 3: start re-pulsed mid-pass and in DONE.
    new_test();
    for (int c = 0; c < 24; c++) tick(0, c == 0 || c == 3 || c == 20, 1);
    chk("t3_done_cyc", 32'(done_cyc), 32'd20);
    chk("t3_idle", 32'(busy), 32'd0);
    chk_order("t3");

    // Test 4: reset mid-pass, then a fresh pass.
    new_test();
    for (int c = 0; c < 10; c++) tick(0, c == 0, 1);
    tick(1, 0, 1);
    expect_zero_idx = 1;
    tick(0, 0, 1);
    new_test();
    for (int c = 0; c < 23; c++) tick(0, c == 0, 1);
    chk("t4_done_cyc", 32'(done_cyc), 32'd20);
    chk_order("t4");

    // Test 6: random 50% randomness availability, several passes.
    for (int p = 0; p < 3; p++) begin
      new_test();
      tick(0, 1, $urandom_range(0, 1));
      for (int c = 0; c < 400 && m_phase != 0; c++) tick(0, 0, $urandom_range(0, 1));
      chk("t6_pass_end", 32'(m_phase), 32'd0);
      chk("t6_done_seen", 32'(done_cyc > 0), 32'd1);
      chk_order("t6");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
